md5_candidate_gen: RTL and testbench
====================================

# md5_candidate_gen

Byte-serial candidate generator sitting directly upstream of `md5_pipeline`. It enumerates every string of a programmed length over a contiguous character range. Each candidate is emitted as one fully padded 64-byte MD5 block, one byte per clock, as the (`offset_out`, `msbyte_out`) pair that drives the pipeline's `offset_in`/`msbyte_in`. The candidate currently on the bus is also exported so a downstream match stage can delay and report it.

## Interface
- `MAX_LEN`, 8: maximum candidate length in bytes (1..8, so the bit length fits one byte).
- `CHARSET_BASE`, 8'h61: first character of the range.
- `CHARSET_SIZE`, 26: number of consecutive characters (1..256-CHARSET_BASE).
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request enumeration; sampled only in IDLE.
- `len_in`  in  4  candidate length L, sampled with `start`.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle pulse after the last byte of the last candidate.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `offset_out`  out  6  free-running block byte offset -> pipeline `offset_in`.
- `msbyte_out`  out  8  block byte at `offset_out` -> pipeline `msbyte_in`.
- `valid_out`  out  1  high for all 64 bytes of a candidate frame.
- `frame_start`  out  1  high when `valid_out` and `offset_out`==0.
- `cand_out`  out  8*MAX_LEN  current candidate, byte i at bits [8i+7:8i], unused bytes 0; stable for the whole frame.

## Operation
- `offset_out` increments by 1 every cycle in all states and wraps 63->0. The pipeline is free-running, and frames always align to offset 0.
- FSM states: IDLE, ARMED, RUN.
  - IDLE: `start`=1 with 1<=L<=MAX_LEN latches L, clears all digits to 0, goes to ARMED. `start` with L=0 or L>MAX_LEN pulses `err` the next cycle and stays IDLE.
  - ARMED: when the next offset is 0, go to RUN. `valid_out` rises with `offset_out`==0.
  - RUN, at `offset_out`==63:
    - If every one of the L digits equals CHARSET_SIZE-1: go to IDLE, pulse `done` next cycle, `valid_out` drops.
    - Otherwise: increment the odometer and stay in RUN.
- Odometer: L digits of width ceil(log2(CHARSET_SIZE)). Digit 0 (byte offset 0) increments fastest. A digit at CHARSET_SIZE-1 wraps to 0 with carry.
- Frame contents for offset k when valid:
  - k<L: CHARSET_BASE+digit[k].
  - k==L: 8'h80.
  - k==56: L*8 (low byte of the little-endian bit length).
  - All other offsets: 0.
- When not valid, `msbyte_out`=0.
- Frames per run = CHARSET_SIZE^L, with no gaps between consecutive frames.
- `start` while `busy`: ignored, no `err`.
- Reset (any cycle, including mid-frame) forces: state IDLE, `offset_out`=0, `msbyte_out`=0, `valid_out`=0, `frame_start`=0, `busy`=0, `done`=0, `err`=0, `cand_out`=0, digits 0.

## Timing
- All outputs are registered. `msbyte_out`, `valid_out`, `frame_start` and `cand_out` are coherent with `offset_out` in the same cycle.
- Start latency: the first valid frame begins at the first cycle with `offset_out`==0 strictly after the cycle `start` was sampled.
  - Start sampled while `offset_out`==63: frame begins in the very next cycle.
  - Start sampled while `offset_out`==0: the frame begins 64 cycles later.
- `cand_out` updates in the same cycle as `offset_out` 63->0 of the next frame.
- `done` is asserted in the cycle with `offset_out`==0 following the final frame. `busy` is already 0 in that cycle.
- `busy` goes to 1 in the cycle after `start` is accepted.

## Structure
- Package `md5_gen_pkg` holds:
  - `MD5_BLOCK_BYTES`=64
  - `MD5_LEN_OFFSET`=56
  - `MD5_PAD_BYTE`=8'h80
  - the FSM state enum (IDLE/ARMED/RUN)
- Sub-module `md5_odometer`: parameterised mixed-radix counter with per-digit wrap, `clear`/`inc` inputs, active-length mask and `all_max` output.
- Top level holds the offset counter, the FSM and the byte mux.

## Test plan
- L=1, defaults, `start` at offset 10:
  - first frame at the next offset 0, bytes off0=8'h61, off1=8'h80, off56=8'h08, rest 0;
  - 26 frames back-to-back, last frame off0=8'h7a;
  - `done` pulses one cycle after that frame's offset 63, `busy` low.
- L=2:
  - frame index 26 (0-based) carries 8'h61, 8'h62, off2=8'h80, off56=8'h10;
  - 676 frames total, with `cand_out` checked every frame.
- L=8 (MAX_LEN): off8=8'h80, off56=8'h40. L=0 and L=9: `err` pulse, `busy` stays 0, `valid_out` stays 0.
- `start` sampled at offset 63 -> `valid_out`=1 with offset 0 the next cycle. A second `start` while `busy` -> no effect, no `err`.
- `rst_n` low at offset 30 of the 5th frame (L=1) -> next cycle: all outputs 0 and `offset_out`=0. A subsequent `start` restarts from 8'h61.
- CHARSET_SIZE=3, L=3 -> exactly 27 frames; the final candidate bytes are 8'h63, 8'h63, 8'h63.

Source files
------------

// File: rtl/md5_gen_pkg.sv
// Shared block-layout constants, FSM encoding and sizing helper for the
// MD5 candidate generator.
package md5_gen_pkg;

  localparam int MD5_BLOCK_BYTES = 64;
  localparam int MD5_LEN_OFFSET = 56;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } gen_state_e;

  // A radix of 1 still needs a one-bit digit so the vectors stay legal.
  function automatic int digit_width(input int radix);
    return (radix > 1) ? $clog2(radix) : 1;
  endfunction

endpackage

// File: rtl/md5_candidate_gen_if.sv
// Control and byte-stream bundle between the candidate generator and its
// controller (master) / the generator itself (slave).
interface md5_candidate_gen_if #(
  parameter int MAX_LEN = 8
);

  logic                   start;
  logic [3:0]             len_in;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [5:0]             offset_out;
  logic [7:0]             msbyte_out;
  logic                   valid_out;
  logic                   frame_start;
  logic [8*MAX_LEN-1:0]   cand_out;

  modport master (
    output start, len_in,
    input  busy, done, err, offset_out, msbyte_out, valid_out, frame_start, cand_out
  );

  modport slave (
    input  start, len_in,
    output busy, done, err, offset_out, msbyte_out, valid_out, frame_start, cand_out
  );

endinterface

// File: rtl/md5_odometer.sv
// Mixed-radix odometer: digit 0 increments fastest, only the first `len`
// digits take part in counting and in the all-maximum test.
module md5_odometer
  import md5_gen_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int RADIX = 26,
  parameter int DIGIT_W = digit_width(RADIX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          inc,
  input  logic [3:0]                    len,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_nxt,
  output logic                          all_max
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_q;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits_d;
  logic                          carry;

  // Next digit values: clear wins over increment; carry ripples upward.
  always_comb begin
    digits_d = digits_q;
    carry    = 1'b1;
    all_max  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((4'(i) < len) && (digits_q[i*DIGIT_W +: DIGIT_W] != DIGIT_MAX)) begin
        all_max = 1'b0;
      end else begin
        all_max = all_max;
      end
    end
    if (clear) begin
      digits_d = '0;
    end else if (inc) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry && (4'(i) < len)) begin
          if (digits_q[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX) begin
            digits_d[i*DIGIT_W +: DIGIT_W] = '0;
          end else begin
            digits_d[i*DIGIT_W +: DIGIT_W] = digits_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
            carry = 1'b0;
          end
        end else begin
          carry = carry;
        end
      end
    end else begin
      digits_d = digits_q;
    end
    digits_nxt = digits_d;
  end

  // Digit register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

endmodule

// File: rtl/md5_candidate_gen.sv
// Byte-serial generator of fully padded single-block MD5 messages that
// enumerates every string of a programmed length over a character range.
module md5_candidate_gen
  import md5_gen_pkg::*;
#(
  parameter int         MAX_LEN      = 8,
  parameter logic [7:0] CHARSET_BASE = 8'h61,
  parameter int         CHARSET_SIZE = 26
) (
  input logic                clk,
  input logic                rst_n,
  md5_candidate_gen_if.slave bus
);

  localparam int         DIGIT_W  = digit_width(CHARSET_SIZE);
  localparam int         CAND_W   = 8 * MAX_LEN;
  localparam logic [5:0] LAST_OFF = 6'(MD5_BLOCK_BYTES - 1);
  localparam logic [5:0] LEN_OFF  = 6'(MD5_LEN_OFFSET);

  gen_state_e          state_q, state_d;
  logic [5:0]          offset_q, offset_d;
  logic [3:0]          len_q, len_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                frame_start_q, frame_start_d;
  logic [7:0]          msbyte_q, msbyte_d;
  logic [CAND_W-1:0]   cand_q, cand_d;

  logic                       len_ok;
  logic                       odo_clear;
  logic                       odo_inc;
  logic                       odo_all_max;
  logic [MAX_LEN*DIGIT_W-1:0] odo_digits_nxt;

  md5_odometer #(
    .NUM_DIGITS (MAX_LEN),
    .RADIX      (CHARSET_SIZE),
    .DIGIT_W    (DIGIT_W)
  ) u_odometer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (odo_clear),
    .inc        (odo_inc),
    .len        (len_q),
    .digits_nxt (odo_digits_nxt),
    .all_max    (odo_all_max)
  );

  // Next state; accepting a start at offset 63 skips ARMED so no frame is lost.
  always_comb begin
    len_ok    = (bus.len_in != 4'd0) && (bus.len_in <= 4'(MAX_LEN));
    offset_d  = offset_q + 6'd1;
    state_d   = state_q;
    len_d     = len_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    odo_clear = 1'b0;
    odo_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && len_ok) begin
          len_d     = bus.len_in;
          odo_clear = 1'b1;
          state_d   = (offset_q == LAST_OFF) ? RUN : ARMED;
        end else if (bus.start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (offset_q == LAST_OFF) begin
          state_d = RUN;
        end else begin
          state_d = ARMED;
        end
      end
      RUN: begin
        if ((offset_q == LAST_OFF) && odo_all_max) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (offset_q == LAST_OFF) begin
          odo_inc = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the next cycle, computed against the next offset and digits.
  always_comb begin
    valid_d       = (state_d == RUN);
    busy_d        = (state_d != IDLE);
    frame_start_d = valid_d && (offset_d == 6'd0);
    cand_d        = '0;
    msbyte_d      = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (valid_d && (4'(i) < len_d)) begin
        cand_d[8*i +: 8] = CHARSET_BASE + 8'(odo_digits_nxt[DIGIT_W*i +: DIGIT_W]);
      end else begin
        cand_d[8*i +: 8] = 8'h00;
      end
    end
    if (!valid_d) begin
      msbyte_d = 8'h00;
    end else if (offset_d < 6'(len_d)) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        msbyte_d = (offset_d == 6'(i)) ? cand_d[8*i +: 8] : msbyte_d;
      end
    end else if (offset_d == 6'(len_d)) begin
      msbyte_d = MD5_PAD_BYTE;
    end else if (offset_d == LEN_OFF) begin
      msbyte_d = {1'b0, len_d, 3'b000};
    end else begin
      msbyte_d = 8'h00;
    end
  end

  // All state and outputs are registered; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      offset_q      <= 6'd0;
      len_q         <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      msbyte_q      <= 8'h00;
      cand_q        <= '0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      len_q         <= len_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      msbyte_q      <= msbyte_d;
      cand_q        <= cand_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.offset_out  = offset_q;
  assign bus.msbyte_out  = msbyte_q;
  assign bus.valid_out   = valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.cand_out    = cand_q;

endmodule

// File: tb/tb_md5_candidate_gen.sv
// Scoreboard bench: expected candidates are queued at start and every byte
// of every frame is compared against a division-based reference model.
module tb_md5_candidate_gen;

  localparam int MAX_LEN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md5_candidate_gen_if #(.MAX_LEN(MAX_LEN)) ifc ();
  md5_candidate_gen_if #(.MAX_LEN(MAX_LEN)) ifc3 ();

  md5_candidate_gen #(.MAX_LEN(MAX_LEN), .CHARSET_BASE(8'h61), .CHARSET_SIZE(26)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
  );

  md5_candidate_gen #(.MAX_LEN(MAX_LEN), .CHARSET_BASE(8'h61), .CHARSET_SIZE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(ifc3.slave)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  bit          sel = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] last_cand;

  logic [5:0]  m_off;
  logic [7:0]  m_byte;
  logic        m_valid, m_fs, m_busy, m_done, m_err;
  logic [63:0] m_cand;

  always_comb begin
    if (sel) begin
      m_off = ifc3.offset_out; m_byte = ifc3.msbyte_out; m_valid = ifc3.valid_out;
      m_fs = ifc3.frame_start; m_busy = ifc3.busy; m_done = ifc3.done;
      m_err = ifc3.err; m_cand = ifc3.cand_out;
    end else begin
      m_off = ifc.offset_out; m_byte = ifc.msbyte_out; m_valid = ifc.valid_out;
      m_fs = ifc.frame_start; m_busy = ifc.busy; m_done = ifc.done;
      m_err = ifc.err; m_cand = ifc.cand_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_cand(input longint idx, input int len, input int size);
    logic [63:0] c;
    longint      v;
    c = 64'h0;
    v = idx;
    for (int i = 0; i < len; i++) begin
      c[8*i +: 8] = 8'h61 + 8'(v % size);
      v = v / size;
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [63:0] cand, input int len, input int k);
    if (k < len) return cand[8*k +: 8];
    else if (k == len) return 8'h80;
    else if (k == 56) return 8'(len * 8);
    else return 8'h00;
  endfunction

  task automatic push_expected(input int len, input int size, input longint first, input longint count);
    for (longint i = first; i < first + count; i++) exp_q.push_back(model_cand(i, len, size));
  endtask

  task automatic do_start(input logic [3:0] len);
    if (sel) begin ifc3.start = 1'b1; ifc3.len_in = len; end
    else begin ifc.start = 1'b1; ifc.len_in = len; end
    tick();
    ifc.start = 1'b0;
    ifc3.start = 1'b0;
  endtask

  task automatic wait_offset(input logic [5:0] target);
    int n;
    n = 0;
    while (m_off !== target && n < 70) begin tick(); n++; end
    n_checks++;
    if (m_off !== target) begin
      n_fail++;
      $display("FAIL wait_offset: offset_out=%0d, required %0d", m_off, target);
    end
  endtask

  task automatic run_frames(input int len, input int n, input bit end_check);
    int          waited;
    logic [63:0] exp;
    logic        exp_fs;
    waited = 0;
    while (m_fs !== 1'b1 && waited < 200) begin tick(); waited++; end
    n_checks++;
    if (m_fs !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_wait: frame_start=%b after %0d cycles, required 1", m_fs, waited);
      return;
    end
    for (int f = 0; f < n; f++) begin
      exp = exp_q.pop_front();
      for (int k = 0; k < 64; k++) begin
        exp_fs = (k == 0);
        n_checks++;
        if (m_off !== 6'(k) || m_valid !== 1'b1 || m_fs !== exp_fs) begin
          n_fail++;
          $display("FAIL framing f%0d k%0d: off=%0d valid=%b fs=%b, required off=%0d valid=1 fs=%b",
                   f, k, m_off, m_valid, m_fs, k, exp_fs);
        end
        n_checks++;
        if (m_byte !== exp_byte(exp, len, k)) begin
          n_fail++;
          $display("FAIL msbyte f%0d k%0d: got %h, required %h", f, k, m_byte, exp_byte(exp, len, k));
        end
        if (k == 0 || k == 63) begin
          n_checks++;
          if (m_cand !== exp) begin
            n_fail++;
            $display("FAIL cand f%0d k%0d: got %h, required %h", f, k, m_cand, exp);
          end
        end
        last_cand = m_cand;
        tick();
      end
    end
    if (end_check) begin
      n_checks++;
      if (m_done !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0 || m_off !== 6'd0) begin
        n_fail++;
        $display("FAIL done_pulse: done=%b busy=%b valid=%b off=%0d, required 1 0 0 0",
                 m_done, m_busy, m_valid, m_off);
      end
      tick();
      n_checks++;
      if (m_done !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL done_single: done=%b valid=%b, required 0 0", m_done, m_valid);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if (m_off !== 6'd0 || m_byte !== 8'h00 || m_valid !== 1'b0 || m_fs !== 1'b0 ||
        m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 1'b0 || m_cand !== 64'h0) begin
      n_fail++;
      $display("FAIL %s: off=%0d byte=%h valid=%b fs=%b busy=%b done=%b err=%b cand=%h, required all 0",
               name, m_off, m_byte, m_valid, m_fs, m_busy, m_done, m_err, m_cand);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (m_off !== 6'd1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: off=%0d valid=%b, required 1 0", m_off, m_valid);
    end
  endtask

  task automatic test_len1();
    int n;
    sel = 1'b0;
    exp_q.delete();
    wait_offset(6'd10);
    do_start(4'd1);
    n_checks++;
    if (m_busy !== 1'b1 || m_off !== 6'd11) begin
      n_fail++;
      $display("FAIL len1_busy: busy=%b off=%0d, required 1 11", m_busy, m_off);
    end
    n = 0;
    while (m_fs !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (n != 53) begin
      n_fail++;
      $display("FAIL len1_latency: %0d cycles, required 53", n);
    end
    push_expected(1, 26, 0, 26);
    run_frames(1, 26, 1'b1);
    n_checks++;
    if (last_cand !== 64'h7a) begin
      n_fail++;
      $display("FAIL len1_last: cand=%h, required 7a", last_cand);
    end
  endtask

  task automatic test_len2();
    int n;
    sel = 1'b0;
    exp_q.delete();
    wait_offset(6'd0);
    do_start(4'd2);
    n = 0;
    while (m_fs !== 1'b1 && n < 100) begin tick(); n++; end
    n_checks++;
    if (n != 63) begin
      n_fail++;
      $display("FAIL len2_latency: %0d cycles, required 63", n);
    end
    push_expected(2, 26, 0, 676);
    run_frames(2, 676, 1'b1);
  endtask

  task automatic test_bad_len();
    logic [3:0] bad[2];
    sel = 1'b0;
    bad[0] = 4'd0;
    bad[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      do_start(bad[i]);
      n_checks++;
      if (m_err !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_len%0d_err: err=%b busy=%b valid=%b, required 1 0 0", bad[i], m_err, m_busy, m_valid);
      end
      tick();
      n_checks++;
      if (m_err !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_len%0d_after: err=%b busy=%b valid=%b, required 0 0 0", bad[i], m_err, m_busy, m_valid);
      end
    end
  endtask

  task automatic test_start_at_63();
    sel = 1'b0;
    exp_q.delete();
    wait_offset(6'd63);
    do_start(4'd1);
    n_checks++;
    if (m_valid !== 1'b1 || m_off !== 6'd0 || m_fs !== 1'b1 || m_busy !== 1'b1 || m_byte !== 8'h61) begin
      n_fail++;
      $display("FAIL start63: valid=%b off=%0d fs=%b busy=%b byte=%h, required 1 0 1 1 61",
               m_valid, m_off, m_fs, m_busy, m_byte);
    end
    do_start(4'd2);
    n_checks++;
    if (m_err !== 1'b0 || m_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: err=%b busy=%b, required 0 1", m_err, m_busy);
    end
    do_start(4'd0);
    n_checks++;
    if (m_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy_bad: err=%b, required 0", m_err);
    end
    push_expected(1, 26, 1, 25);
    run_frames(1, 25, 1'b1);
  endtask

  task automatic test_len8();
    sel = 1'b0;
    exp_q.delete();
    do_start(4'd8);
    push_expected(8, 26, 0, 2);
    run_frames(8, 2, 1'b0);
    rst_n = 1'b0;
    tick();
    check_all_zero("len8_reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    exp_q.delete();
    do_start(4'd1);
    push_expected(1, 26, 0, 4);
    run_frames(1, 4, 1'b0);
    wait_offset(6'd30);
    n_checks++;
    if (m_valid !== 1'b1 || m_cand !== 64'h65) begin
      n_fail++;
      $display("FAIL frame5_live: valid=%b cand=%h, required 1 65", m_valid, m_cand);
    end
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    do_start(4'd1);
    push_expected(1, 26, 0, 26);
    run_frames(1, 26, 1'b1);
  endtask

  task automatic test_charset3();
    sel = 1'b1;
    exp_q.delete();
    do_start(4'd3);
    push_expected(3, 3, 0, 27);
    run_frames(3, 27, 1'b1);
    n_checks++;
    if (last_cand !== 64'h636363) begin
      n_fail++;
      $display("FAIL cs3_last: cand=%h, required 636363", last_cand);
    end
    sel = 1'b0;
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.len_in = 4'd0;
    ifc3.start = 1'b0;
    ifc3.len_in = 4'd0;
    last_cand = 64'h0;
    test_reset();
    test_len1();
    test_bad_len();
    test_start_at_63();
    test_len8();
    test_mid_reset();
    test_charset3();
    test_len2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
